// File: rtl/lfsr_checker_if.sv
// Stream/status bundle between an LFSR bit source and lfsr_checker.
// The checker side uses the slave modport; the source/monitor side uses master.
interface lfsr_checker_if #(
   parameter int ERR_W = 16
);
   logic             i_Valid;
   logic             i_Bit;
   logic             i_Clear;
   logic             o_Locked;
   logic             o_Err;
   logic [ERR_W-1:0] o_Err_Count;

   modport master (
      output i_Valid, i_Bit, i_Clear,
      input  o_Locked, o_Err, o_Err_Count
   );

   modport slave (
      input  i_Valid, i_Bit, i_Clear,
      output o_Locked, o_Err, o_Err_Count
   );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the two-tap LFSR stream (SEED -> HUNT -> LOCKED).
// Optional feature macro: LFSR_CHECK_FLYWHEEL_EN (regenerate locally while locked).
module lfsr_checker #(
   parameter int DEPTH      = 12,
   parameter int TAP1       = 4,
   parameter int TAP2       = 7,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_ERR = 4,
   parameter int ERR_W      = 16
) (
   input  logic           i_Clk,
   input  logic           i_Rst_n,
   lfsr_checker_if.slave  bus
);
   localparam int SEED_W = $clog2(DEPTH + 1);
   localparam int CNT_W  = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_ERR + 1);

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             state_r, state_nx_s;
   logic [DEPTH-1:0]   s_r, s_nx_s;
   logic [SEED_W-1:0]  seed_cnt_r, seed_cnt_nx_s;
   logic [CNT_W-1:0]   match_cnt_r, match_cnt_nx_s;
   logic [CNT_W-1:0]   run_cnt_r, run_cnt_nx_s;
   logic [BAD_W-1:0]   bad_cnt_r, bad_cnt_nx_s;
   logic [ERR_W-1:0]   err_cnt_r, err_cnt_nx_s;
   logic               err_r, err_nx_s;
   logic               locked_r;
   logic               pred_s, mism_s, shift_bit_s, inc_s;

   function automatic logic predict(input logic [DEPTH-1:0] s);
      return s[TAP1] ^ s[TAP2];
   endfunction

   assign pred_s = predict(s_r);
   assign mism_s = bus.i_Bit ^ pred_s;

   // Next-state, counters and shift-register update for one valid bit
   always_comb begin
      state_nx_s     = state_r;
      s_nx_s         = s_r;
      seed_cnt_nx_s  = seed_cnt_r;
      match_cnt_nx_s = match_cnt_r;
      run_cnt_nx_s   = run_cnt_r;
      bad_cnt_nx_s   = bad_cnt_r;
      err_nx_s       = 1'b0;
      inc_s          = 1'b0;
      shift_bit_s    = bus.i_Bit;
      if (bus.i_Valid) begin
         case (state_r)
            ST_SEED: begin
               if (seed_cnt_r == SEED_W'(DEPTH - 1)) begin
                  state_nx_s     = ST_HUNT;
                  seed_cnt_nx_s  = {SEED_W{1'b0}};
                  match_cnt_nx_s = {CNT_W{1'b0}};
               end else begin
                  seed_cnt_nx_s = seed_cnt_r + SEED_W'(1);
               end
            end
            ST_HUNT: begin
               // an all-zero register predicts zeros forever, so it never counts as a match
               if (!mism_s && (s_r != {DEPTH{1'b0}})) begin
                  if (match_cnt_r == CNT_W'(LOCK_CNT - 1)) begin
                     state_nx_s     = ST_LOCKED;
                     match_cnt_nx_s = {CNT_W{1'b0}};
                     run_cnt_nx_s   = {CNT_W{1'b0}};
                     bad_cnt_nx_s   = {BAD_W{1'b0}};
                  end else begin
                     match_cnt_nx_s = match_cnt_r + CNT_W'(1);
                  end
               end else begin
                  match_cnt_nx_s = {CNT_W{1'b0}};
               end
            end
            ST_LOCKED: begin
`ifdef LFSR_CHECK_FLYWHEEL_EN
               shift_bit_s = pred_s;
`else
               shift_bit_s = bus.i_Bit;
`endif
               if (mism_s) begin
                  err_nx_s     = 1'b1;
                  inc_s        = 1'b1;
                  run_cnt_nx_s = {CNT_W{1'b0}};
                  if (bad_cnt_r == BAD_W'(UNLOCK_ERR - 1)) begin
                     state_nx_s    = ST_SEED;
                     bad_cnt_nx_s  = {BAD_W{1'b0}};
                     seed_cnt_nx_s = {SEED_W{1'b0}};
                  end else begin
                     bad_cnt_nx_s = bad_cnt_r + BAD_W'(1);
                  end
               end else begin
                  if (run_cnt_r == CNT_W'(LOCK_CNT - 1)) begin
                     run_cnt_nx_s = {CNT_W{1'b0}};
                     bad_cnt_nx_s = {BAD_W{1'b0}};
                  end else begin
                     run_cnt_nx_s = run_cnt_r + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_nx_s    = ST_SEED;
               seed_cnt_nx_s = {SEED_W{1'b0}};
            end
         endcase
         s_nx_s = {s_r[DEPTH-2:0], shift_bit_s};
      end else begin
         s_nx_s = s_r;
      end
   end

   // Saturating error counter; clear beats a same-cycle increment
   always_comb begin
      err_cnt_nx_s = err_cnt_r;
      if (bus.i_Clear) begin
         err_cnt_nx_s = {ERR_W{1'b0}};
      end else if (inc_s && (err_cnt_r != {ERR_W{1'b1}})) begin
         err_cnt_nx_s = err_cnt_r + ERR_W'(1);
      end else begin
         err_cnt_nx_s = err_cnt_r;
      end
   end

   // State, counter and registered-output update
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_r     <= ST_SEED;
         s_r         <= {DEPTH{1'b0}};
         seed_cnt_r  <= {SEED_W{1'b0}};
         match_cnt_r <= {CNT_W{1'b0}};
         run_cnt_r   <= {CNT_W{1'b0}};
         bad_cnt_r   <= {BAD_W{1'b0}};
         err_cnt_r   <= {ERR_W{1'b0}};
         err_r       <= 1'b0;
         locked_r    <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         s_r         <= s_nx_s;
         seed_cnt_r  <= seed_cnt_nx_s;
         match_cnt_r <= match_cnt_nx_s;
         run_cnt_r   <= run_cnt_nx_s;
         bad_cnt_r   <= bad_cnt_nx_s;
         err_cnt_r   <= err_cnt_nx_s;
         err_r       <= err_nx_s;
         locked_r    <= (state_nx_s == ST_LOCKED);
      end
   end

   assign bus.o_Locked    = locked_r;
   assign bus.o_Err       = err_r;
   assign bus.o_Err_Count = err_cnt_r;
endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised self-checking bench for lfsr_checker against a queue-based behavioural model.
module tb_lfsr_checker;
   localparam int DEPTH      = 12;
   localparam int TAP1       = 4;
   localparam int TAP2       = 7;
   localparam int LOCK_CNT   = 16;
   localparam int UNLOCK_ERR = 4;
   localparam int ERR_W      = 16;
`ifdef LFSR_CHECK_FLYWHEEL_EN
   localparam int EXP_SINGLE = 1;
   localparam bit FLYWHEEL   = 1'b1;
`else
   localparam int EXP_SINGLE = 3;
   localparam bit FLYWHEEL   = 1'b0;
`endif

   logic i_Clk = 1'b0;
   logic i_Rst_n;
   always #5 i_Clk = ~i_Clk;

   lfsr_checker_if #(.ERR_W(ERR_W)) bus ();

   lfsr_checker #(
      .DEPTH(DEPTH), .TAP1(TAP1), .TAP2(TAP2),
      .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .ERR_W(ERR_W)
   ) dut (
      .i_Clk  (i_Clk),
      .i_Rst_n(i_Rst_n),
      .bus    (bus)
   );

   int total  = 0;
   int n_bad  = 0;

   // behavioural model: history of shifted bits, newest at index 0
   bit hist[$];
   int m_phase;      // 0 filling, 1 hunting, 2 locked
   int m_seen, m_streak, m_errs, m_run, m_cnt;
   bit m_err, m_locked;

   logic [DEPTH-1:0] gen_r;
   bit zero_src;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back(1'b0);
      m_phase = 0; m_seen = 0; m_streak = 0; m_errs = 0; m_run = 0;
      m_cnt = 0; m_err = 1'b0; m_locked = 1'b0;
   endtask

   task automatic model_step(input bit valid, input bit b, input bit clr);
      bit pred, shifted, any_one, inc;
      m_err = 1'b0;
      inc   = 1'b0;
      if (valid) begin
         pred    = hist[TAP1] ^ hist[TAP2];
         shifted = b;
         any_one = 1'b0;
         foreach (hist[i]) if (hist[i]) any_one = 1'b1;
         if (m_phase == 0) begin
            m_seen++;
            if (m_seen == DEPTH) begin m_phase = 1; m_streak = 0; end
         end else if (m_phase == 1) begin
            m_streak = (b == pred && any_one) ? m_streak + 1 : 0;
            if (m_streak == LOCK_CNT) begin m_phase = 2; m_errs = 0; m_run = 0; end
         end else begin
            if (FLYWHEEL) shifted = pred;
            if (b != pred) begin
               m_err = 1'b1; inc = 1'b1; m_errs++; m_run = 0;
               if (m_errs == UNLOCK_ERR) begin m_phase = 0; m_seen = 0; m_errs = 0; end
            end else begin
               m_run++;
               if (m_run == LOCK_CNT) begin m_run = 0; m_errs = 0; end
            end
         end
         hist.push_front(shifted);
         void'(hist.pop_back());
      end
      if (clr) m_cnt = 0;
      else if (inc && m_cnt < (1 << ERR_W) - 1) m_cnt++;
      m_locked = (m_phase == 2);
   endtask

   // one clock: drive, advance model, then compare all outputs
   task automatic cycle(input bit valid, input bit flip, input bit clr);
      logic b;
      if (valid) begin
         gen_r = {gen_r[DEPTH-2:0], gen_r[TAP1] ^ gen_r[TAP2]};
         b = (zero_src ? 1'b0 : gen_r[0]) ^ flip;
      end else begin
         b = 1'($urandom_range(0, 1));
      end
      bus.i_Valid = valid;
      bus.i_Bit   = b;
      bus.i_Clear = clr;
      @(posedge i_Clk);
      model_step(valid, b, clr);
      #1;
      check("locked", 32'(bus.o_Locked), 32'(m_locked));
      check("err", 32'(bus.o_Err), 32'(m_err));
      check("err_count", 32'(bus.o_Err_Count), 32'(m_cnt));
   endtask

   task automatic run_bits(input int n, input int duty);
      int done = 0;
      while (done < n) begin
         if ($urandom_range(0, 99) < duty) begin
            cycle(1'b1, 1'b0, 1'b0);
            done++;
         end else begin
            cycle(1'b0, 1'b0, 1'b0);
         end
      end
   endtask

   task automatic do_reset();
      i_Rst_n     = 1'b0;
      bus.i_Valid = 1'b1;
      bus.i_Bit   = 1'b1;
      bus.i_Clear = 1'b0;
      @(posedge i_Clk);
      model_reset();
      #1;
      check("rst_locked", 32'(bus.o_Locked), 32'd0);
      check("rst_err", 32'(bus.o_Err), 32'd0);
      check("rst_count", 32'(bus.o_Err_Count), 32'd0);
      i_Rst_n = 1'b1;
      gen_r   = DEPTH'(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      zero_src    = 1'b0;
      gen_r       = DEPTH'(1);
      i_Rst_n     = 1'b0;
      bus.i_Valid = 1'b0;
      bus.i_Bit   = 1'b0;
      bus.i_Clear = 1'b0;
      model_reset();
      @(posedge i_Clk);
      #1;
      do_reset();

      // clean stream: lock exactly at valid bit DEPTH+LOCK_CNT, then no errors
      run_bits(DEPTH + LOCK_CNT - 1, 100);
      check("lock_before_28", 32'(bus.o_Locked), 32'd0);
      run_bits(1, 100);
      check("lock_at_28", 32'(bus.o_Locked), 32'd1);
      run_bits(1000, 100);
      check("clean_count", 32'(bus.o_Err_Count), 32'd0);

      // single flipped bit
      cycle(1'b1, 1'b1, 1'b0);
      check("single_pulse", 32'(bus.o_Err), 32'd1);
      run_bits(40, 100);
      check("single_count", 32'(bus.o_Err_Count), 32'(EXP_SINGLE));
      check("single_locked", 32'(bus.o_Locked), 32'd1);

      // four consecutive flips drop lock, then relock after DEPTH+LOCK_CNT good bits
      for (int i = 0; i < UNLOCK_ERR - 1; i++) cycle(1'b1, 1'b1, 1'b0);
      check("burst_still_locked", 32'(bus.o_Locked), 32'd1);
      cycle(1'b1, 1'b1, 1'b0);
      check("burst_unlock", 32'(bus.o_Locked), 32'd0);
      check("burst_count", 32'(bus.o_Err_Count), 32'(EXP_SINGLE + UNLOCK_ERR));
      run_bits(DEPTH + LOCK_CNT - 1, 100);
      check("relock_before", 32'(bus.o_Locked), 32'd0);
      run_bits(1, 100);
      check("relock_at", 32'(bus.o_Locked), 32'd1);

      // reset while locked, then clear racing an error
      do_reset();
      run_bits(DEPTH + LOCK_CNT, 100);
      check("lock_after_rst", 32'(bus.o_Locked), 32'd1);
      cycle(1'b1, 1'b1, 1'b0);
      run_bits(40, 100);
      check("pre_clear_count", 32'(bus.o_Err_Count), 32'(EXP_SINGLE));
      cycle(1'b1, 1'b1, 1'b1);
      check("clear_vs_err_pulse", 32'(bus.o_Err), 32'd1);
      check("clear_vs_err_count", 32'(bus.o_Err_Count), 32'd0);
      run_bits(40, 100);
      cycle(1'b0, 1'b0, 1'b1);
      check("clear_idle", 32'(bus.o_Err_Count), 32'd0);
      check("clear_keeps_lock", 32'(bus.o_Locked), 32'd1);

      // all-zero stream never locks
      do_reset();
      zero_src = 1'b1;
      run_bits(200, 100);
      check("zero_locked", 32'(bus.o_Locked), 32'd0);
      check("zero_count", 32'(bus.o_Err_Count), 32'd0);
      zero_src = 1'b0;

      // random valid gaps: same lock point in valid bits
      do_reset();
      run_bits(DEPTH + LOCK_CNT - 1, 50);
      check("gap_lock_before", 32'(bus.o_Locked), 32'd0);
      run_bits(1, 50);
      check("gap_lock_at", 32'(bus.o_Locked), 32'd1);
      run_bits(300, 50);
      check("gap_count", 32'(bus.o_Err_Count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, n_bad);
      $finish;
   end
endmodule
